// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, result capture, in-order commit and flush.
// Optional ROB_BYPASS_EN forwards the writeback broadcast straight to operand queries.
module reorder_buffer #(
    parameter int TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic             issue_is_br,
    input  logic             issue_pred_taken,
    input  logic [31:0]      issue_alt_pc,
    output logic             rob_full,
    output logic [TAG_W-1:0] issue_tag,
    output logic [4:0]       set_reg_q_1,
    output logic [31:0]      set_val_q_1,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_val,
    input  logic             wb_taken,
    input  logic [TAG_W-1:0] query_tag_1,
    input  logic [TAG_W-1:0] query_tag_2,
    output logic             query_ready_1,
    output logic             query_ready_2,
    output logic [31:0]      query_val_1,
    output logic [31:0]      query_val_2,
    output logic [4:0]       set_reg,
    output logic [31:0]      set_val,
    output logic [4:0]       set_reg_q_2,
    output logic [31:0]      set_val_q_2,
    output logic             RoB_clear,
    output logic [31:0]      clear_pc
);

    localparam int DEPTH = 2 ** TAG_W;
    localparam logic [TAG_W:0] FULL_CNT = {1'b1, {TAG_W{1'b0}}};
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] ready_q;
    logic [DEPTH-1:0] br_q;
    logic [DEPTH-1:0] pt_q;
    logic [DEPTH-1:0] tkn_q;
    logic [4:0]       rd_q  [DEPTH];
    logic [31:0]      val_q [DEPTH];
    logic [31:0]      alt_q [DEPTH];

    logic [4:0]  set_reg_q, set_reg2_q;
    logic [31:0] set_val_q, set_val2_q;
    logic        clear_q;
    logic [31:0] clear_pc_q;

    logic        run;
    logic        issue_fire;
    logic        wb_fire;
    logic        commit;
    logic        mispred;
    logic [4:0]  commit_rd;

    always_comb begin
        rob_full   = (count_q == FULL_CNT) || (state_q == FLUSH);
        run        = rdy_in && (state_q == RUN);
        issue_fire = issue_valid && !rob_full && rdy_in;
        wb_fire    = wb_valid && run && busy_q[wb_tag];
        commit     = run && busy_q[head_q] && ready_q[head_q];
        mispred    = commit && br_q[head_q] &&
                     (tkn_q[head_q] != pt_q[head_q]);
        commit_rd  = br_q[head_q] ? 5'd0 : rd_q[head_q];
    end

    always_comb begin
        head_d  = commit ? head_q + TAG_W'(1) : head_q;
        tail_d  = issue_fire ? tail_q + TAG_W'(1) : tail_q;
        count_d = count_q;
        if (issue_fire && !commit) count_d = count_q + (TAG_W+1)'(1);
        if (!issue_fire && commit) count_d = count_q - (TAG_W+1)'(1);
        state_d = RUN;
        if (mispred) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = FLUSH;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= RUN;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            ready_q    <= '0;
            br_q       <= '0;
            pt_q       <= '0;
            tkn_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]  <= '0;
                val_q[i] <= '0;
                alt_q[i] <= '0;
            end
            set_reg_q  <= '0;
            set_reg2_q <= '0;
            set_val_q  <= '0;
            set_val2_q <= '0;
            clear_q    <= 1'b0;
            clear_pc_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            set_reg_q  <= commit ? commit_rd : 5'd0;
            set_reg2_q <= commit ? commit_rd : 5'd0;
            clear_q    <= mispred;
            if (commit) begin
                set_val_q  <= val_q[head_q];
                set_val2_q <= 32'(head_q);
            end
            if (mispred) clear_pc_q <= alt_q[head_q];
            if (issue_fire) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                rd_q[tail_q]    <= issue_rd;
                br_q[tail_q]    <= issue_is_br;
                pt_q[tail_q]    <= issue_pred_taken;
                alt_q[tail_q]   <= issue_alt_pc;
            end
            if (wb_fire) begin
                ready_q[wb_tag] <= 1'b1;
                val_q[wb_tag]   <= wb_val;
                tkn_q[wb_tag]   <= wb_taken;
            end
            if (commit) busy_q[head_q] <= 1'b0;
            if (mispred) busy_q <= '0;
        end else begin
            // a stalled cycle must never replay the previous commit pulse
            set_reg_q  <= '0;
            set_reg2_q <= '0;
        end
    end

    always_comb begin
        issue_tag     = tail_q;
        set_reg_q_1   = issue_fire ? issue_rd : 5'd0;
        set_val_q_1   = 32'(tail_q);
        set_reg       = rdy_in ? set_reg_q : 5'd0;
        set_reg_q_2   = rdy_in ? set_reg2_q : 5'd0;
        set_val       = set_val_q;
        set_val_q_2   = set_val2_q;
        RoB_clear     = clear_q;
        clear_pc      = clear_pc_q;
        query_ready_1 = busy_q[query_tag_1] && ready_q[query_tag_1];
        query_val_1   = val_q[query_tag_1];
        query_ready_2 = busy_q[query_tag_2] && ready_q[query_tag_2];
        query_val_2   = val_q[query_tag_2];
`ifdef ROB_BYPASS_EN
        if (wb_valid && wb_tag == query_tag_1) begin
            query_ready_1 = 1'b1;
            query_val_1   = wb_val;
        end
        if (wb_valid && wb_tag == query_tag_2) begin
            query_ready_2 = 1'b1;
            query_val_2   = wb_val;
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: vector table plus commit scoreboard.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_is_br;
    logic        issue_pred_taken;
    logic [31:0] issue_alt_pc;
    logic        rob_full;
    logic [3:0]  issue_tag;
    logic [4:0]  set_reg_q_1;
    logic [31:0] set_val_q_1;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_val;
    logic        wb_taken;
    logic [3:0]  query_tag_1, query_tag_2;
    logic        query_ready_1, query_ready_2;
    logic [31:0] query_val_1, query_val_2;
    logic [4:0]  set_reg;
    logic [31:0] set_val;
    logic [4:0]  set_reg_q_2;
    logic [31:0] set_val_q_2;
    logic        RoB_clear;
    logic [31:0] clear_pc;

    reorder_buffer #(.TAG_W(4)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_is_br(issue_is_br), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc), .rob_full(rob_full),
        .issue_tag(issue_tag), .set_reg_q_1(set_reg_q_1),
        .set_val_q_1(set_val_q_1), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .wb_val(wb_val), .wb_taken(wb_taken),
        .query_tag_1(query_tag_1), .query_tag_2(query_tag_2),
        .query_ready_1(query_ready_1), .query_ready_2(query_ready_2),
        .query_val_1(query_val_1), .query_val_2(query_val_2),
        .set_reg(set_reg), .set_val(set_val),
        .set_reg_q_2(set_reg_q_2), .set_val_q_2(set_val_q_2),
        .RoB_clear(RoB_clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0] rd;
        logic [3:0] tag;
        logic       full;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  tag;
    } exp_t;

    vec_t vecs[17];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; issue_is_br = 0;
        issue_pred_taken = 0; issue_alt_pc = 0;
        wb_valid = 0; wb_tag = 0; wb_val = 0; wb_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n_in = 0;
        tick();
        tick();
        rst_n_in = 1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] v,
                        input logic [3:0] t);
        exp_t e;
        e.rd = rd; e.val = v; e.tag = t;
        exp_q.push_back(e);
    endtask

    // commit monitor: every nonzero commit pulse must match the queue head
    always @(negedge clk_in) begin
        if (rst_n_in && set_reg != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", 32'(set_reg), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_reg", 32'(set_reg), 32'(e.rd));
                chk("commit_val", set_val, e.val);
                chk("commit_reg_q2", 32'(set_reg_q_2), 32'(e.rd));
                chk("commit_tag", set_val_q_2, 32'(e.tag));
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            vecs[i].rd   = 5'(i + 1);
            vecs[i].tag  = 4'(i);
            vecs[i].full = 1'b0;
        end
        vecs[16].rd   = 5'd20;
        vecs[16].tag  = 4'd0;
        vecs[16].full = 1'b1;

        rdy_in = 1; query_tag_1 = 0; query_tag_2 = 0;
        idle_inputs();
        rst_n_in = 0;
        tick();
        tick();
        chk("rst_full", 32'(rob_full), 0);
        chk("rst_tag", 32'(issue_tag), 0);
        chk("rst_set_reg", 32'(set_reg), 0);
        chk("rst_set_val", set_val, 0);
        chk("rst_clear", 32'(RoB_clear), 0);
        chk("rst_clear_pc", clear_pc, 0);
        rst_n_in = 1;

        // in-order commit with out-of-order writeback
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_rd = 5;
            #1;
            chk("t1_tag", 32'(issue_tag), 32'(i));
            chk("t1_q1_reg", 32'(set_reg_q_1), 5);
            chk("t1_q1_val", set_val_q_1, 32'(i));
            tick();
        end
        issue_valid = 0;
        push(5, 32'hAA, 0);
        push(5, 32'h11, 1);
        push(5, 32'h22, 2);
        wb_valid = 1; wb_tag = 1; wb_val = 32'h11;
        tick();
        wb_tag = 0; wb_val = 32'hAA;
        tick();
        wb_tag = 2; wb_val = 32'h22;
        tick();
        wb_valid = 0;
        repeat (5) tick();
        chk("t1_drained", exp_q.size(), 0);

        // fill to full, reject, then wrap
        do_reset();
        for (int i = 0; i < 17; i++) begin
            issue_valid = 1; issue_rd = vecs[i].rd;
            #1;
            chk("t2_full", 32'(rob_full), 32'(vecs[i].full));
            chk("t2_tag", 32'(issue_tag), 32'(vecs[i].tag));
            chk("t2_q1_reg", 32'(set_reg_q_1),
                vecs[i].full ? 32'd0 : 32'(vecs[i].rd));
            tick();
        end
        issue_valid = 0;
        push(1, 32'h77, 0);
        wb_valid = 1; wb_tag = 0; wb_val = 32'h77;
        tick();
        wb_valid = 0;
        issue_valid = 1; issue_rd = 21;
        #1;
        chk("t2_commit_cycle_full", 32'(rob_full), 1);
        chk("t2_commit_cycle_rej", 32'(set_reg_q_1), 0);
        tick();
        chk("t2_after_full", 32'(rob_full), 0);
        chk("t2_wrap_tag", 32'(issue_tag), 0);
        chk("t2_accept", 32'(set_reg_q_1), 21);
        tick();
        issue_valid = 0;
        #1;
        chk("t2_refull", 32'(rob_full), 1);
        chk("t2_drained", exp_q.size(), 0);

        // mispredicted branch flush
        do_reset();
        issue_valid = 1; issue_rd = 0; issue_is_br = 1;
        issue_pred_taken = 0; issue_alt_pc = 32'h1000;
        tick();
        idle_inputs();
        wb_valid = 1; wb_tag = 0; wb_val = 0; wb_taken = 1;
        tick();
        wb_valid = 0; wb_taken = 0;
        chk("t3_no_clear_yet", 32'(RoB_clear), 0);
        tick();
        chk("t3_clear", 32'(RoB_clear), 1);
        chk("t3_clear_pc", clear_pc, 32'h1000);
        chk("t3_flush_full", 32'(rob_full), 1);
        chk("t3_br_no_reg", 32'(set_reg), 0);
        issue_valid = 1; issue_rd = 7;
        #1;
        chk("t3_flush_rej", 32'(set_reg_q_1), 0);
        tick();
        issue_valid = 0;
        chk("t3_clear_pulse", 32'(RoB_clear), 0);
        chk("t3_run_full", 32'(rob_full), 0);
        chk("t3_tag0", 32'(issue_tag), 0);
        query_tag_1 = 0;
        #1;
        chk("t3_no_entry", 32'(query_ready_1), 0);

        // stall with a ready head
        do_reset();
        issue_valid = 1; issue_rd = 9;
        tick();
        issue_valid = 0;
        wb_valid = 1; wb_tag = 0; wb_val = 32'h99;
        tick();
        wb_valid = 0;
        rdy_in = 0;
        push(9, 32'h99, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall_reg", 32'(set_reg), 0);
            chk("t4_stall_reg_q2", 32'(set_reg_q_2), 0);
        end
        rdy_in = 1;
        tick();
        chk("t4_commit", 32'(set_reg), 9);
        tick();
        chk("t4_single", 32'(set_reg), 0);
        chk("t4_drained", exp_q.size(), 0);

        // writeback visibility to queries
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1; issue_rd = 1;
            tick();
        end
        issue_valid = 0;
        query_tag_1 = 3;
        wb_valid = 1; wb_tag = 3; wb_val = 32'h55;
        #1;
`ifdef ROB_BYPASS_EN
        chk("t5_same_rdy", 32'(query_ready_1), 1);
        chk("t5_same_val", query_val_1, 32'h55);
`else
        chk("t5_same_rdy", 32'(query_ready_1), 0);
`endif
        tick();
        wb_valid = 0;
        #1;
        chk("t5_next_rdy", 32'(query_ready_1), 1);
        chk("t5_next_val", query_val_1, 32'h55);
        wb_valid = 1; wb_tag = 7; wb_val = 32'h66;
        tick();
        wb_valid = 0;
        query_tag_2 = 7;
        #1;
        chk("t5_nonbusy_ign", 32'(query_ready_2), 0);

        // asynchronous reset mid-cycle with 4 in flight
        push(1, 32'h5A, 0);
        wb_valid = 1; wb_tag = 0; wb_val = 32'h5A;
        tick();
        wb_valid = 0;
        tick();
        tick();
        chk("t6_set_val_pre", set_val, 32'h5A);
        chk("t6_q_pre", 32'(query_ready_1), 1);
        #2;
        rst_n_in = 0;
        #1;
        chk("t6_full", 32'(rob_full), 0);
        chk("t6_tag", 32'(issue_tag), 0);
        chk("t6_set_val", set_val, 0);
        chk("t6_set_reg", 32'(set_reg), 0);
        chk("t6_q", 32'(query_ready_1), 0);
        tick();
        rst_n_in = 1;
        tick();
        chk("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
